// File: rtl/alu_pkg.sv
// Shared ALU control-word field constants and the arbiter state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_SEL_ADD   = 3'd0;
    localparam logic [2:0] ALU_SEL_AND   = 3'd1;
    localparam logic [2:0] ALU_SEL_XOR   = 3'd2;
    localparam logic [2:0] ALU_SEL_SHIFT = 3'd4;
    localparam logic [2:0] ALU_SEL_CMP   = 3'd5;

    localparam int unsigned ALU_NEG_BIT   = 7;
    localparam int unsigned ALU_SEL_MSB   = 6;
    localparam int unsigned ALU_SEL_LSB   = 4;
    localparam int unsigned ALU_BGATE_MSB = 3;
    localparam int unsigned ALU_BGATE_LSB = 2;
    localparam int unsigned ALU_AGATE_MSB = 1;
    localparam int unsigned ALU_AGATE_LSB = 0;

    localparam logic [7:0] ALU_CTRL_NOP  = 8'h00;
    localparam logic [7:0] ALU_CTRL_SUB  = 8'h82;  // ~(~a + b) = a - b
    localparam logic [7:0] ALU_CTRL_SLTU = 8'h51;
    localparam logic [7:0] ALU_CTRL_SLT  = 8'h50;

    typedef enum logic [0:0] {
        ARB,
        LOCK1
    } arb_state_e;

    function automatic logic [7:0] alu_ctrl_word(input logic       neg,
                                                 input logic [2:0] sel,
                                                 input logic [1:0] bgate,
                                                 input logic [1:0] agate);
        return {neg, sel, bgate, agate};
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester handshake and response bundle between issue logic and the ALU arbiter.
interface alu_arbiter_if;

    logic        r0_valid;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [7:0]  r0_ctrl;
    logic        r0_ready;

    logic        r1_valid;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [7:0]  r1_ctrl;
    logic        r1_lock;
    logic        r1_ready;

    logic        rsp0_valid;
    logic [31:0] rsp0_y;
    logic        rsp1_valid;
    logic [31:0] rsp1_y;

    modport master (
        output r0_valid, r0_a, r0_b, r0_ctrl,
        output r1_valid, r1_a, r1_b, r1_ctrl, r1_lock,
        input  r0_ready, r1_ready,
        input  rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_ctrl,
        input  r1_valid, r1_a, r1_b, r1_ctrl, r1_lock,
        output r0_ready, r1_ready,
        output rsp0_valid, rsp0_y, rsp1_valid, rsp1_y
    );

endinterface

// File: rtl/alu_arb_sat_ctr.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module alu_arb_sat_ctr #(
    parameter int unsigned Width  = 4,
    parameter int unsigned MaxVal = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Width'(MaxVal))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (r0) and the mul/div sequencer (r1),
// with r0 priority, an r1 starvation guard and a bounded r1 lock.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus_io,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [7:0]  alu_ctrl_o,
    input  logic [31:0] alu_y_i,
    output logic        lock_abort_o
);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_cnt;
    logic [7:0]  lock_cnt;
    logic        wait_full, lock_last;
    logic        gnt0, gnt1;
    logic        lock_release, force_release;
    logic        wait_clr, wait_inc;
    logic        rsp0_valid_q, rsp1_valid_q, lock_abort_q;
    logic [31:0] rsp0_y_q, rsp1_y_q;

    assign wait_full = (wait_cnt == 4'(MAX_WAIT));
    assign lock_last = (lock_cnt == 8'(LOCK_MAX - 1));

    // Grants are masked by rst so every output reads 0 while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (bus_io.r1_valid && (wait_full || !bus_io.r0_valid)) begin
                        gnt1 = 1'b1;
                    end else if (bus_io.r0_valid) begin
                        gnt0 = 1'b1;
                    end
                end
                LOCK1: gnt1 = bus_io.r1_valid;
                default: ;
            endcase
        end
    end

    assign lock_release  = (state_q == LOCK1) && gnt1 && !bus_io.r1_lock;
    assign force_release = (state_q == LOCK1) && lock_last && !lock_release;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (gnt1 && bus_io.r1_lock) state_d = LOCK1;
            LOCK1:   if (lock_release || force_release) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = ALU_CTRL_NOP;
        if (gnt0) begin
            alu_a_o    = bus_io.r0_a;
            alu_b_o    = bus_io.r0_b;
            alu_ctrl_o = bus_io.r0_ctrl;
        end else if (gnt1) begin
            alu_a_o    = bus_io.r1_a;
            alu_b_o    = bus_io.r1_b;
            alu_ctrl_o = bus_io.r1_ctrl;
        end
    end

    assign wait_clr = !bus_io.r1_valid || gnt1 || force_release;
    assign wait_inc = bus_io.r1_valid && !gnt1;

    alu_arb_sat_ctr #(
        .Width  (4),
        .MaxVal (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wait_clr),
        .inc_i (wait_inc),
        .cnt_o (wait_cnt)
    );

    // Held at zero in ARB so it starts from 0 on every entry to LOCK1.
    alu_arb_sat_ctr #(
        .Width  (8),
        .MaxVal (LOCK_MAX - 1)
    ) u_lock_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ARB),
        .inc_i (state_q == LOCK1),
        .cnt_o (lock_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
            lock_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp0_valid_q <= gnt0;
            rsp1_valid_q <= gnt1;
            lock_abort_q <= force_release;
            if (gnt0) rsp0_y_q <= alu_y_i;
            if (gnt1) rsp1_y_q <= alu_y_i;
        end
    end

    assign bus_io.r0_ready   = gnt0;
    assign bus_io.r1_ready   = gnt1;
    assign bus_io.rsp0_valid = rsp0_valid_q;
    assign bus_io.rsp0_y     = rsp0_y_q;
    assign bus_io.rsp1_valid = rsp1_valid_q;
    assign bus_io.rsp1_y     = rsp1_y_q;
    assign lock_abort_o      = lock_abort_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with MAX_WAIT = 4, LOCK_MAX = 8.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [7:0]  alu_ctrl;
    logic        lock_abort;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if bus ();

    alu_arbiter #(
        .MAX_WAIT (4),
        .LOCK_MAX (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_io       (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_y_i      (alu_y),
        .lock_abort_o (lock_abort)
    );

    // Stand-in ALU: add, sub, and an xor mix for any other ctrl word.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [7:0] c);
        case (c)
            8'h00:   return a + b;
            8'h82:   return a - b;
            default: return a ^ b ^ {24'h0, c};
        endcase
    endfunction

    assign alu_y = alu_model(alu_a, alu_b, alu_ctrl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0v, input logic [31:0] r0a, input logic [31:0] r0b,
                         input logic [7:0] r0c, input logic r1v, input logic [31:0] r1a,
                         input logic [31:0] r1b, input logic [7:0] r1c, input logic r1l);
        bus.r0_valid = r0v;
        bus.r0_a     = r0a;
        bus.r0_b     = r0b;
        bus.r0_ctrl  = r0c;
        bus.r1_valid = r1v;
        bus.r1_a     = r1a;
        bus.r1_b     = r1b;
        bus.r1_ctrl  = r1c;
        bus.r1_lock  = r1l;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        r0v;
        logic [31:0] r0a;
        logic [31:0] r0b;
        logic [7:0]  r0c;
        logic        r1v;
        logic [31:0] r1a;
        logic [31:0] r1b;
        logic [7:0]  r1c;
        logic        e_r0rdy;
        logic        e_r1rdy;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [7:0]  e_c;
        logic        e_rsp0;
        logic        e_rsp1;
        logic [31:0] e_y;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"idle", 0, 0, 0, 8'h00, 0, 0, 0, 8'h00,
                    0, 0, 0, 0, 8'h00, 0, 0, 0};
        vecs[1] = '{"r0_sub", 1, 7, 5, 8'h82, 0, 0, 0, 8'h00,
                    1, 0, 7, 5, 8'h82, 1, 0, 32'd2};
        vecs[2] = '{"r1_add", 0, 0, 0, 8'h00, 1, 1, 2, 8'h00,
                    0, 1, 1, 2, 8'h00, 0, 1, 32'd3};
        vecs[3] = '{"both_r0_wins", 1, 10, 3, 8'h00, 1, 100, 1, 8'h00,
                    1, 0, 10, 3, 8'h00, 1, 0, 32'd13};
        vecs[4] = '{"r0_sltu_pass", 1, 3, 9, 8'h51, 0, 0, 0, 8'h00,
                    1, 0, 3, 9, 8'h51, 1, 0, 32'h0000_005B};
        vecs[5] = '{"r1_slt_pass", 0, 0, 0, 8'h00, 1, 32'hFFFF_FFFF, 1, 8'h50,
                    0, 1, 32'hFFFF_FFFF, 1, 8'h50, 0, 1, 32'hFFFF_FFAE};
        vecs[6] = '{"r0_sub_wrap", 1, 0, 1, 8'h82, 0, 0, 0, 8'h00,
                    1, 0, 0, 1, 8'h82, 1, 0, 32'hFFFF_FFFF};

        // Reset state
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_r0_ready", bus.r0_ready, 0);
        check("rst_r1_ready", bus.r1_ready, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_lock_abort", lock_abort, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // Single-transaction vectors: combinational grant/ALU drive, then the response pulse
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].r0v, vecs[i].r0a, vecs[i].r0b, vecs[i].r0c,
                  vecs[i].r1v, vecs[i].r1a, vecs[i].r1b, vecs[i].r1c, 1'b0);
            #1;
            check({vecs[i].name, "_r0_ready"}, bus.r0_ready, vecs[i].e_r0rdy);
            check({vecs[i].name, "_r1_ready"}, bus.r1_ready, vecs[i].e_r1rdy);
            check({vecs[i].name, "_alu_a"}, alu_a, vecs[i].e_a);
            check({vecs[i].name, "_alu_b"}, alu_b, vecs[i].e_b);
            check({vecs[i].name, "_alu_ctrl"}, alu_ctrl, vecs[i].e_c);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check({vecs[i].name, "_rsp0_valid"}, bus.rsp0_valid, vecs[i].e_rsp0);
            check({vecs[i].name, "_rsp1_valid"}, bus.rsp1_valid, vecs[i].e_rsp1);
            if (vecs[i].e_rsp0) check({vecs[i].name, "_rsp0_y"}, bus.rsp0_y, vecs[i].e_y);
            if (vecs[i].e_rsp1) check({vecs[i].name, "_rsp1_y"}, bus.rsp1_y, vecs[i].e_y);
            @(negedge clk);
        end
        check("hold_rsp1_y", bus.rsp1_y, 32'hFFFF_FFAE);
        check("hold_rsp0_y", bus.rsp0_y, 32'hFFFF_FFFF);

        // Starvation guard: r0 cycles 0-3, r1 forced on cycle 4, r0 again on cycle 5
        drive(1, 1, 1, 8'h00, 1, 2, 2, 8'h00, 0);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("starve_c%0d_r0_ready", c), bus.r0_ready, (c != 4));
            check($sformatf("starve_c%0d_r1_ready", c), bus.r1_ready, (c == 4));
            @(negedge clk);
        end
        idle_cycle();

        // Locked chain: r1 wins after starving, then holds the ALU for three dependent ops
        drive(1, 50, 50, 8'h00, 1, 1, 2, 8'h00, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("chain_c%0d_r0_ready", c), bus.r0_ready, 1);
            @(negedge clk);
        end
        #1;
        check("chain_op1_r1_ready", bus.r1_ready, 1);
        check("chain_op1_alu_a", alu_a, 1);
        @(negedge clk);
        drive(1, 50, 50, 8'h00, 1, 3, 4, 8'h00, 1);
        #1;
        check("chain_op2_rsp1_valid", bus.rsp1_valid, 1);
        check("chain_op2_rsp1_y", bus.rsp1_y, 3);
        check("chain_op2_r1_ready", bus.r1_ready, 1);
        check("chain_op2_r0_ready", bus.r0_ready, 0);
        @(negedge clk);
        drive(1, 50, 50, 8'h00, 1, 5, 6, 8'h00, 0);
        #1;
        check("chain_op3_rsp1_y", bus.rsp1_y, 7);
        check("chain_op3_r1_ready", bus.r1_ready, 1);
        check("chain_op3_r0_ready", bus.r0_ready, 0);
        @(negedge clk);
        drive(1, 50, 50, 8'h00, 0, 0, 0, 8'h00, 0);
        #1;
        check("chain_end_rsp1_y", bus.rsp1_y, 11);
        check("chain_end_rsp1_valid", bus.rsp1_valid, 1);
        check("chain_end_r0_ready", bus.r0_ready, 1);
        @(negedge clk);
        idle_cycle();

        // Lock timeout with LOCK_MAX = 8: r0 blocked 8 cycles, one abort pulse, then r0
        drive(0, 0, 0, 8'h00, 1, 9, 1, 8'h00, 1);
        #1;
        check("tmo_lock_r1_ready", bus.r1_ready, 1);
        @(negedge clk);
        drive(1, 30, 3, 8'h00, 0, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 8; k++) begin
            #1;
            check($sformatf("tmo_k%0d_r0_ready", k), bus.r0_ready, 0);
            check($sformatf("tmo_k%0d_lock_abort", k), lock_abort, 0);
            if (k == 1) check("tmo_rsp1_y", bus.rsp1_y, 10);
            if (k == 2) check("tmo_idle_alu_a", alu_a, 0);
            @(negedge clk);
        end
        #1;
        check("tmo_abort_pulse", lock_abort, 1);
        check("tmo_r0_granted", bus.r0_ready, 1);
        @(negedge clk);
        #1;
        check("tmo_abort_single", lock_abort, 0);
        @(negedge clk);
        idle_cycle();

        // Asynchronous reset while locked with an r1 transfer pending
        drive(0, 0, 0, 8'h00, 1, 2, 2, 8'h00, 1);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 1, 4, 4, 8'h00, 1);
        #1;
        check("arst_pre_r1_ready", bus.r1_ready, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_r1_ready", bus.r1_ready, 0);
        check("arst_r0_ready", bus.r0_ready, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_rsp1_valid", bus.rsp1_valid, 0);
        check("arst_rsp1_y", bus.rsp1_y, 0);
        check("arst_lock_abort", lock_abort, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 20, 1, 8'h00, 1, 4, 4, 8'h00, 0);
        #1;
        check("arst_no_rsp1", bus.rsp1_valid, 0);
        check("arst_r0_first", bus.r0_ready, 1);
        check("arst_r1_denied", bus.r1_ready, 0);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        check("arst_rsp0_valid", bus.rsp0_valid, 1);
        check("arst_rsp0_y", bus.rsp0_y, 21);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters.
  - Requester 0 is the execute stage.
  - Requester 1 is the iterative mul/div sequencer, which issues chains of dependent ALU ops.
- Arbitration is fixed-priority toward requester 0, with a starvation guard and an optional lock for requester 1.
- Results are registered and returned one cycle after the grant.
- Sits between the issue logic and the ALU instance; owns the ALU a/b/ctrl inputs.

Parameters:
- MAX_WAIT, 4: consecutive denied cycles of requester 1 before it is force-granted over requester 0. Legal range 1..15.
- LOCK_MAX, 64: maximum consecutive cycles requester 1 may hold a lock before forced release. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- r0_valid  in  1  requester 0 has an op.
- r0_a  in  32  requester 0 operand a.
- r0_b  in  32  requester 0 operand b.
- r0_ctrl  in  8  requester 0 ALU ctrl word.
- r0_ready  out  1  requester 0 op accepted this cycle.
- r1_valid  in  1  requester 1 has an op.
- r1_a  in  32  requester 1 operand a.
- r1_b  in  32  requester 1 operand b.
- r1_ctrl  in  8  requester 1 ALU ctrl word.
- r1_lock  in  1  requester 1 keeps ownership after this op.
- r1_ready  out  1  requester 1 op accepted this cycle.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_ctrl  out  8  ALU ctrl word.
- alu_y  in  32  ALU result, combinational from alu_a/alu_b/alu_ctrl.
- rsp0_valid  out  1  requester 0 result valid.
- rsp0_y  out  32  requester 0 result.
- rsp1_valid  out  1  requester 1 result valid.
- rsp1_y  out  32  requester 1 result.
- lock_abort  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (asynchronous, active-high): all outputs, registers and counters cleared to 0; state = ARB.
- Handshake: transfer = valid && ready. ready is combinational from state and valids; at most one ready per cycle.
  - ready never depends on the same-cycle ready of the other requester.
- ALU drive: the granted requester's a/b/ctrl drive alu_*. With no grant, alu_a = 0, alu_b = 0, alu_ctrl = 8'h00 (add, result 0).
- Latency: on a transfer, alu_y is captured at the clock edge.
  - The next cycle has rspN_valid = 1 and rspN_y = captured value.
  - rspN_valid is a one-cycle pulse and is not back-pressured.
  - rsp*_y holds its last value when not valid.
- State ARB:
  - Grant r0 if r0_valid, unless wait_cnt == MAX_WAIT, in which case r1 is granted.
  - Otherwise grant r1 if r1_valid.
- wait_cnt (4 bits):
  - +1 each cycle r1_valid && !r1_ready.
  - Cleared on an r1 transfer, and on any cycle r1_valid = 0.
  - Saturates at MAX_WAIT.
- ARB -> LOCK1: on an r1 transfer with r1_lock = 1.
- State LOCK1:
  - r0_ready = 0.
  - r1_ready = r1_valid.
  - The ALU idles while r1_valid = 0, and the lock is retained.
- lock_cnt (8 bits): cleared on entry to LOCK1, +1 each cycle in LOCK1.
- LOCK1 -> ARB when either:
  - an r1 transfer occurs with r1_lock = 0 (that op completes normally); or
  - lock_cnt reaches LOCK_MAX - 1 with no lock-clearing transfer in that cycle. Then lock_abort pulses in the following cycle, any transfer in that final cycle is still honoured, and wait_cnt is cleared.
- On return to ARB, r0 is eligible in the very next cycle.
- Simultaneous r0/r1 valid with wait_cnt < MAX_WAIT: r0 wins.
- Reset mid-operation: the pending rsp pulse is dropped and the lock is released; no response is issued for an op accepted in the reset cycle.
- Ctrl words pass through unmodified; the arbiter does not decode ALU semantics.

Decomposition:
- Shared package alu_pkg holds the ALU ctrl field constants:
  - ALU_SEL_ADD = 0, ALU_SEL_AND = 1, ALU_SEL_XOR = 2, ALU_SEL_SHIFT = 4, ALU_SEL_CMP = 5.
  - Bit positions: negate output = bit 7, select = bits 6:4, b gating = bits 3:2, a gating = bits 1:0.
  - Canned words: ALU_CTRL_NOP = 8'h00, ALU_CTRL_SUB = 8'h82 (computes ~(~a + b) = a - b), ALU_CTRL_SLTU = 8'h51, ALU_CTRL_SLT = 8'h50.
  - The arbiter state enum {ARB, LOCK1}.
- One sub-module, alu_arb_sat_ctr: a parameterised saturating counter with clear, instantiated for both wait_cnt and lock_cnt.

Test Plan:
- r0 only, a = 7, b = 5, ctrl = 8'h82, one cycle -> r0_ready = 1; next cycle rsp0_valid = 1, rsp0_y = 2; rsp1_valid stays 0.
- r0 and r1 valid continuously, MAX_WAIT = 4 -> r0 granted cycles 0-3, r1 granted cycle 4, wait_cnt cleared, r0 resumes cycle 5.
- r1 issues 3 ops (1+2, 3+4, 5+6, ctrl 8'h00) with r1_lock = 1, 1, 0 while r0_valid = 1 -> rsp1_y = 3, 7, 11 on consecutive cycles; r0_ready = 0 throughout, then r0 granted the cycle after the lock-clearing transfer.
- r1 locks, then holds r1_valid = 0 with LOCK_MAX = 8 -> r0 blocked for 8 cycles, lock_abort pulses once, r0 granted the next cycle.
- rst asserted asynchronously mid-clock while r1 is locked with a transfer pending -> all outputs 0 immediately, no rsp pulse after release, state ARB, and r0 is granted first after reset.
- Idle (no valids) -> alu_a = 0, alu_b = 0, alu_ctrl = 8'h00, both ready low, no rsp pulses.
